// File: rtl/data_mem_io.sv
// Data-side memory for the single-cycle CPU: word RAM plus an MMIO page holding
// an LED register, a free-running timer with compare flag, and an 8N1 UART transmitter.
module data_mem_io #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LED,
    output logic        irq,
    output logic        uart_tx
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Word offsets inside the MMIO page (Addr[7:2])
    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_TCOUNT = 6'h01;
    localparam logic [5:0] OFF_TCMP   = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_UARTTX = 6'h04;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [5:0]    mmio_off;
    logic          wr_led;
    logic          wr_tcount;
    logic          wr_tcmp;
    logic          wr_status;
    logic          wr_uart;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   tcount;
    logic [31:0]   tcmp;
    logic          match_flag;

    uart_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic          uart_busy;
    logic          uart_accept;

    // Address decode; byte offset bits are ignored everywhere
    assign ram_hit   = Addr < RAM_BYTES;
    assign mmio_hit  = Addr[31:8] == MMIO_BASE[31:8];
    assign ram_idx   = Addr[AW+1:2];
    assign mmio_off  = Addr[7:2];

    assign wr_led    = MemWrite && mmio_hit && (mmio_off == OFF_LED);
    assign wr_tcount = MemWrite && mmio_hit && (mmio_off == OFF_TCOUNT);
    assign wr_tcmp   = MemWrite && mmio_hit && (mmio_off == OFF_TCMP);
    assign wr_status = MemWrite && mmio_hit && (mmio_off == OFF_STATUS);
    assign wr_uart   = MemWrite && mmio_hit && (mmio_off == OFF_UARTTX);

    // Data RAM: contents survive reset
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LED <= '0;
        end else if (wr_led) begin
            LED <= WriteData[7:0];
        end
    end

    // Timer: a load beats the increment, and a new match beats a W1C clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount     <= '0;
            tcmp       <= '1;
            match_flag <= 1'b0;
        end else begin
            tcount <= wr_tcount ? WriteData : tcount + 32'd1;
            if (wr_tcmp) begin
                tcmp <= WriteData;
            end
            if (tcount == tcmp) begin
                match_flag <= 1'b1;
            end else if (wr_status && WriteData[0]) begin
                match_flag <= 1'b0;
            end
        end
    end

    assign irq         = match_flag;
    assign uart_busy   = state != IDLE;
    assign uart_accept = wr_uart && !uart_busy;

    // UART transmitter; the line level is registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (uart_accept) begin
                        state   <= START;
                        tx_byte <= WriteData[7:0];
                        baud    <= '0;
                        uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        uart_tx <= tx_byte[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= tx_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        state <= IDLE;
                        baud  <= '0;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Combinational load path so loads complete in the same cycle
    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_LED:    ReadData = {24'd0, LED};
                OFF_TCOUNT: ReadData = tcount;
                OFF_TCMP:   ReadData = tcmp;
                OFF_STATUS: ReadData = {30'd0, uart_busy, match_flag};
                OFF_UARTTX: ReadData = {24'd0, tx_byte};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed vector table, timer/UART/reset sequences,
// then random traffic checked every cycle against a behavioural model.
module tb_data_mem_io;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned CPB   = 4;
    localparam logic [31:0] MMIO     = 32'hFFFF_0000;
    localparam logic [23:0] PAGE     = 24'hFFFF00;
    localparam logic [31:0] A_LED    = MMIO + 32'h00;
    localparam logic [31:0] A_TCOUNT = MMIO + 32'h04;
    localparam logic [31:0] A_TCMP   = MMIO + 32'h08;
    localparam logic [31:0] A_STATUS = MMIO + 32'h0C;
    localparam logic [31:0] A_UART   = MMIO + 32'h10;
    localparam logic [31:0] A_UNMAP  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  LED;
    logic        irq;
    logic        uart_tx;

    always #5 clk = ~clk;

    data_mem_io #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .LED(LED), .irq(irq),
        .uart_tx(uart_tx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: RAM array, timer arithmetic, UART as "cycles since accept"
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];
    logic [7:0]  m_led;
    logic [7:0]  m_byte;
    logic [31:0] m_tcount;
    logic [31:0] m_tcmp;
    logic        m_flag;
    logic        m_busy;
    int          m_k;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_led    = '0;
        m_byte   = '0;
        m_tcount = '0;
        m_tcmp   = '1;
        m_flag   = 1'b0;
        m_busy   = 1'b0;
        m_k      = 0;
    endtask

    function automatic logic m_tx();
        int seg;
        if (!m_busy) return 1'b1;
        seg = m_k / CPB;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return m_byte[seg-1];
        return 1'b1;
    endfunction

    function automatic logic m_known(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) return m_valid[a[7:2]];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] off;
        if (a < 32'(DEPTH * 4)) return m_mem[a[7:2]];
        if (a[31:8] != PAGE) return 32'd0;
        off = a[7:0] & 8'hFC;
        case (off)
            8'h00:   return {24'd0, m_led};
            8'h04:   return m_tcount;
            8'h08:   return m_tcmp;
            8'h0C:   return {30'd0, m_busy, m_flag};
            8'h10:   return {24'd0, m_byte};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] pre_count;
        logic [31:0] pre_cmp;
        logic        was_busy;
        logic        mm;
        logic [7:0]  off;
        pre_count = m_tcount;
        pre_cmp   = m_tcmp;
        was_busy  = m_busy;
        mm        = (a[31:8] == PAGE);
        off       = a[7:0] & 8'hFC;
        if (m_busy) begin
            m_k++;
            if (m_k == 10 * CPB) m_busy = 1'b0;
        end
        if (we && a < 32'(DEPTH * 4)) begin
            m_mem[a[7:2]]   = d;
            m_valid[a[7:2]] = 1'b1;
        end
        m_tcount = (we && mm && off == 8'h04) ? d : pre_count + 32'd1;
        if (we && mm && off == 8'h00) m_led = d[7:0];
        if (we && mm && off == 8'h08) m_tcmp = d;
        if (pre_count == pre_cmp) m_flag = 1'b1;
        else if (we && mm && off == 8'h0C && d[0]) m_flag = 1'b0;
        if (we && mm && off == 8'h10 && !was_busy) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_byte = d[7:0];
        end
    endtask

    // One bus cycle: called just after a rising edge, samples before the next one
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic tx, output logic iq);
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        #1;
        rd = ReadData;
        tx = uart_tx;
        iq = irq;
        if (m_known(a)) check("rdata", ReadData, m_read(a));
        check("led", 32'(LED), 32'(m_led));
        check("irq", 32'(irq), 32'(m_flag));
        check("uart_tx", 32'(uart_tx), 32'(m_tx()));
        @(posedge clk);
        m_step(we, a, d);
        #1;
    endtask

    logic [31:0] rd_s;
    logic        tx_s;
    logic        irq_s;
    logic        seen;
    logic [9:0]  frame;
    logic        we_r;
    logic [31:0] a_r;
    logic [31:0] d_r;
    int          r;

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        tbl[0]  = '{1'b0, A_LED,            32'h0,         1'b1, 32'h0000_0000};
        tbl[1]  = '{1'b0, A_TCMP,           32'h0,         1'b1, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b0, A_STATUS,         32'h0,         1'b1, 32'h0000_0000};
        tbl[3]  = '{1'b0, A_UART,           32'h0,         1'b1, 32'h0000_0000};
        tbl[4]  = '{1'b1, 32'h0000_0010,    32'hDEADBEEF,  1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0000_0010,    32'h0,         1'b1, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, 32'h0000_0013,    32'h0,         1'b1, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, A_UNMAP,          32'h0,         1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, A_LED,            32'h1234_5678, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, A_LED,            32'h0,         1'b1, 32'h0000_0078};
        tbl[10] = '{1'b0, A_LED + 32'd3,    32'h0,         1'b1, 32'h0000_0078};
        tbl[11] = '{1'b1, A_UNMAP,          32'h0000_0055, 1'b0, 32'h0};
        tbl[12] = '{1'b0, A_UNMAP,          32'h0,         1'b1, 32'h0000_0000};
        tbl[13] = '{1'b1, MMIO + 32'h14,    32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[14] = '{1'b0, MMIO + 32'h14,    32'h0,         1'b1, 32'h0000_0000};
        tbl[15] = '{1'b1, 32'h0000_00FC,    32'hCAFEF00D,  1'b0, 32'h0};
        tbl[16] = '{1'b0, 32'h0000_00FC,    32'h0,         1'b1, 32'hCAFEF00D};
        tbl[17] = '{1'b0, 32'h0000_0100,    32'h0,         1'b1, 32'h0000_0000};
        tbl[18] = '{1'b1, 32'h0000_0010,    32'h1111_1111, 1'b1, 32'hDEADBEEF};
        tbl[19] = '{1'b0, 32'h0000_0010,    32'h0,         1'b1, 32'h1111_1111};
        tbl[20] = '{1'b1, 32'hFFFE_0000,    32'h0000_00FF, 1'b0, 32'h0};
        tbl[21] = '{1'b0, A_LED,            32'h0,         1'b1, 32'h0000_0078};

        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        m_reset();

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].wd, rd_s, tx_s, irq_s);
            if (tbl[i].chk) check($sformatf("vec%0d", i), rd_s, tbl[i].exp);
        end

        // Timer: match at 10, W1C, then wrap through zero to match at 1
        drive(1'b1, A_TCMP, 32'd10, rd_s, tx_s, irq_s);
        drive(1'b1, A_TCOUNT, 32'd0, rd_s, tx_s, irq_s);
        drive(1'b1, A_STATUS, 32'd1, rd_s, tx_s, irq_s);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, A_TCOUNT, 32'd0, rd_s, tx_s, irq_s);
            if (irq_s) begin
                check("irq_rise_count", rd_s, 32'd11);
                seen = 1'b1;
                break;
            end
        end
        check("irq_rise_seen", 32'(seen), 32'd1);
        drive(1'b1, A_STATUS, 32'd1, rd_s, tx_s, irq_s);
        drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);
        check("w1c_status", rd_s & 32'd1, 32'd0);
        check("w1c_irq", 32'(irq_s), 32'd0);
        drive(1'b1, A_TCOUNT, 32'hFFFF_FFFE, rd_s, tx_s, irq_s);
        drive(1'b1, A_TCMP, 32'd1, rd_s, tx_s, irq_s);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, A_TCOUNT, 32'd0, rd_s, tx_s, irq_s);
            if (irq_s) begin
                check("wrap_rise_count", rd_s, 32'd2);
                seen = 1'b1;
                break;
            end
        end
        check("wrap_rise_seen", 32'(seen), 32'd1);

        // UART frame for 0xA5 with a dropped write in the middle
        frame = {1'b1, 8'hA5, 1'b0};
        drive(1'b1, A_UART, 32'h0000_00A5, rd_s, tx_s, irq_s);
        for (int k = 0; k < 40; k++) begin
            if (k == 10) drive(1'b1, A_UART, 32'h0000_003C, rd_s, tx_s, irq_s);
            else         drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);
            check($sformatf("uart_wave_k%0d", k), 32'(tx_s), 32'(frame[k / CPB]));
            if (k == 10) check("uart_drop_read", rd_s, 32'h0000_00A5);
            else         check("uart_busy", 32'(rd_s[1]), 32'd1);
        end
        drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);
        check("uart_idle_busy", 32'(rd_s[1]), 32'd0);
        check("uart_idle_tx", 32'(tx_s), 32'd1);
        drive(1'b0, A_UART, 32'd0, rd_s, tx_s, irq_s);
        check("uart_last_byte", rd_s, 32'h0000_00A5);
        drive(1'b1, A_UART, 32'h0000_003C, rd_s, tx_s, irq_s);
        drive(1'b0, A_UART, 32'd0, rd_s, tx_s, irq_s);
        check("uart_new_start", 32'(tx_s), 32'd0);
        check("uart_new_byte", rd_s, 32'h0000_003C);
        for (int k = 0; k < 40; k++) drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);

        // Async reset in the middle of data bit 3
        drive(1'b1, A_LED, 32'h0000_005A, rd_s, tx_s, irq_s);
        drive(1'b1, A_TCMP, m_tcount + 32'd2, rd_s, tx_s, irq_s);
        drive(1'b1, A_UART, 32'h0000_0096, rd_s, tx_s, irq_s);
        for (int k = 0; k < 17; k++) drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);
        check("pre_rst_irq", 32'(irq_s), 32'd1);
        check("pre_rst_busy", 32'(rd_s[1]), 32'd1);
        MemWrite = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_uart_tx", 32'(uart_tx), 32'd1);
        check("mid_rst_led", 32'(LED), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        Addr = A_STATUS;
        #1;
        check("mid_rst_status", ReadData, 32'd0);
        Addr = A_UART;
        #1;
        check("mid_rst_uartreg", ReadData, 32'd0);
        Addr = A_TCMP;
        #1;
        check("mid_rst_tcmp", ReadData, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        drive(1'b0, 32'h0000_0010, 32'd0, rd_s, tx_s, irq_s);
        check("ram_after_rst", rd_s, 32'h1111_1111);
        drive(1'b0, A_STATUS, 32'd0, rd_s, tx_s, irq_s);
        check("status_after_rst", rd_s, 32'd0);
        check("tx_after_rst", 32'(tx_s), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r    = int'($urandom_range(0, 11));
            we_r = 1'($urandom_range(0, 1));
            d_r  = $urandom;
            case (r)
                0, 1, 2: a_r = 32'($urandom_range(0, DEPTH * 4 - 1));
                3:       a_r = 32'($urandom_range(DEPTH * 4, 32'h0000_FFFF));
                4:       a_r = A_LED | 32'($urandom_range(0, 3));
                5:       a_r = A_TCOUNT;
                6: begin
                    a_r = A_TCMP;
                    d_r = m_tcount + 32'($urandom_range(1, 12));
                end
                7:       a_r = A_STATUS;
                8, 9:    a_r = A_UART;
                10:      a_r = MMIO | 32'($urandom_range(0, 255));
                default: a_r = $urandom;
            endcase
            drive(we_r, a_r, d_r, rd_s, tx_s, irq_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Data-side memory system that consumes the single-cycle CPU's memory outputs (MemWrite, ALUResult as address, WriteData) and produces its ReadData input. It combines word-addressed data RAM with a memory-mapped I/O page. The page holds an LED register, a free-running timer with compare/match flag, and an 8N1 UART transmitter. The read path is combinational so the CPU completes loads in one cycle; every write commits on the rising clock edge.

Parameters:
DEPTH, 64, number of 32-bit RAM words (power of two)
CLKS_PER_BIT, 868, clocks per UART bit period (>=2)
MMIO_BASE, 32'hFFFF_0000, base address of the I/O page

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  store enable from CPU
Addr  input  32  byte address (CPU ALUResult)
WriteData  input  32  store data from CPU
ReadData  output  32  load data to CPU, combinational from Addr
LED  output  8  LED register
irq  output  1  timer match flag
uart_tx  output  1  serial TX line, idle high

Behaviour:
- Decode, Addr[1:0] ignored:
  - RAM hit when Addr < DEPTH*4; word index is Addr[log2(DEPTH)+1:2].
  - MMIO hit when Addr[31:8] == MMIO_BASE[31:8]; offset is Addr[7:0].
  - Anything else is unmapped: reads return 0, writes are ignored.
- MMIO map:
  - 0x00 LED: RW, bits[7:0]; reads zero-extend.
  - 0x04 TCOUNT: RW; a write loads the counter.
  - 0x08 TCMP: RW.
  - 0x0C STATUS: bit0 match flag (write 1 clears), bit1 uart_busy (RO); other bits read 0.
  - 0x10 UARTTX: a write with busy=0 latches WriteData[7:0] and starts a frame. A write with busy=1 is silently dropped. Reads return the last accepted byte.
  - Other offsets: read 0, write ignored.
- RAM: write on clk edge when MemWrite and RAM hit. Contents are not cleared by reset (initial content X). Read-during-write returns old data combinationally; new data is visible the next cycle.
- Timer:
  - TCOUNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A TCOUNT write takes precedence over the increment that cycle.
  - Match flag sets on the edge where the pre-edge TCOUNT == TCMP.
  - A simultaneous W1C and set: set wins.
  - irq = match flag.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1, busy=0. An accepted UARTTX write moves to START on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index plus a baud counter cleared on each bit.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy=1 in every state other than IDLE.
  - Frame length is 10*CLKS_PER_BIT cycles from the accepting edge.
  - A new write is accepted on or after the edge that returns the FSM to IDLE.
- Reset, async, mid-operation included:
  - LED=0, TCOUNT=0, TCMP=0xFFFF_FFFF, flag=0, irq=0.
  - UART returns to IDLE: uart_tx=1 immediately, busy=0, counters 0, TX byte 0.
  - An in-flight frame is aborted.
  - ReadData follows the reset register values combinationally.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, load 0x0000_0010 and 0x0000_0013 next cycle -> ReadData=0xDEADBEEF for both; load 0x0000_1000 (DEPTH=64) -> 0.
- Store 0x1234_5678 to MMIO_BASE+0x00 -> LED=0x78; read -> 0x0000_0078.
- Release reset, write TCMP=10 -> irq rises on the edge after TCOUNT==10. Write STATUS=1 -> irq=0. Write TCOUNT=0xFFFF_FFFE and TCMP=1 -> count wraps through 0 and irq sets again.
- CLKS_PER_BIT=4, write UARTTX=0xA5 -> uart_tx = 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles; STATUS bit1 reads 1 for 40 cycles, then 0.
- During that frame, write UARTTX=0x3C -> dropped; waveform unchanged and UARTTX reads 0xA5. After return to IDLE, write 0x3C -> new frame starts.
- Assert reset during DATA bit 3 -> uart_tx=1 and busy=0 asynchronously, LED=0, irq=0; RAM contents written before reset are still readable.
